// File: rtl/clk_ratio_detector.sv
// Measures an incoming slow clock against clk: recovers its integer period and
// high time, emits synchronized edge strobes and declares lock on stable periods.
module clk_ratio_detector #(
    parameter int  MAX_FACTOR  = 16,
    parameter int  LOCK_COUNT  = 4,
    parameter int  SYNC_STAGES = 2,
    localparam int WIDTH       = $clog2(MAX_FACTOR + 2)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             iclk,
    output logic             iclk_sync,
    output logic             rise,
    output logic             fall,
    output logic [WIDTH-1:0] factor,
    output logic [WIDTH-1:0] high_time,
    output logic             locked,
    output logic             error
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] TWO  = WIDTH'(2);
    localparam logic [WIDTH-1:0] MAXF = WIDTH'(MAX_FACTOR);
    localparam logic [WIDTH-1:0] SAT  = WIDTH'(MAX_FACTOR + 1);

    localparam logic [MW:0] MATCH_ONE   = (MW + 1)'(1);
    localparam logic [MW:0] LOCK_TARGET = (MW + 1)'(LOCK_COUNT);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_MEASURE = 2'd2;
    localparam logic [1:0] S_LOCKED  = 2'd3;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev;
    logic [1:0]             state;
    logic [WIDTH-1:0]       pcnt;
    logic [WIDTH-1:0]       hcnt;
    logic [WIDTH-1:0]       cand_p;
    logic [WIDTH-1:0]       cand_h;
    logic [MW-1:0]          match;
    logic [MW:0]            next_match;
    logic                   period_bad;
    logic                   timeout;

    assign iclk_sync  = sync_q[SYNC_STAGES-1];
    assign period_bad = (pcnt < TWO) || (pcnt > MAXF) || (cand_h == '0);
    assign timeout    = (state != S_IDLE) && (pcnt == SAT);
    assign next_match = (pcnt == cand_p) ? ({1'b0, match} + MATCH_ONE) : MATCH_ONE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], iclk};
            prev   <= iclk_sync;
            rise   <= iclk_sync & ~prev;
            fall   <= ~iclk_sync & prev;
        end
    end

    // hcnt follows prev so that the value seen in the fall cycle equals the
    // number of clk cycles iclk_sync spent high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pcnt      <= '0;
            hcnt      <= '0;
            cand_p    <= '0;
            cand_h    <= '0;
            match     <= '0;
            factor    <= '0;
            high_time <= '0;
            locked    <= 1'b0;
            error     <= 1'b0;
        end else if (!enable) begin
            state  <= S_IDLE;
            pcnt   <= '0;
            hcnt   <= '0;
            cand_p <= '0;
            cand_h <= '0;
            match  <= '0;
            locked <= 1'b0;
            error  <= 1'b0;
        end else begin
            error <= 1'b0;

            if (rise) begin
                pcnt <= ONE;
                hcnt <= ONE;
            end else begin
                if (pcnt != SAT) pcnt <= pcnt + ONE;
                if (prev && (hcnt != SAT)) hcnt <= hcnt + ONE;
            end

            if (fall) cand_h <= hcnt;
            else if (rise) cand_h <= '0;

            case (state)
                S_IDLE: begin
                    if (rise) state <= S_ARMED;
                end
                S_ARMED, S_MEASURE, S_LOCKED: begin
                    if (rise && period_bad) begin
                        error  <= 1'b1;
                        locked <= 1'b0;
                        match  <= '0;
                        state  <= S_IDLE;
                    end else if (rise) begin
                        if (state == S_ARMED) begin
                            cand_p <= pcnt;
                            match  <= MATCH_ONE[MW-1:0];
                            state  <= S_MEASURE;
                        end else if (state == S_MEASURE) begin
                            cand_p <= pcnt;
                            match  <= next_match[MW-1:0];
                            if (next_match >= LOCK_TARGET) begin
                                factor    <= pcnt;
                                high_time <= cand_h;
                                locked    <= 1'b1;
                                state     <= S_LOCKED;
                            end
                        end else if (pcnt == factor) begin
                            high_time <= cand_h;
                        end else begin
                            error  <= 1'b1;
                            locked <= 1'b0;
                            cand_p <= pcnt;
                            match  <= MATCH_ONE[MW-1:0];
                            state  <= S_MEASURE;
                        end
                    end else if (timeout) begin
                        error  <= 1'b1;
                        locked <= 1'b0;
                        match  <= '0;
                        pcnt   <= '0;
                        state  <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_detector.sv
// Directed bench for clk_ratio_detector: iclk is driven as whole periods
// aligned to clk, and lock/error/edge behaviour is checked at known cycles.
module tb_clk_ratio_detector;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             enable = 1'b1;
    logic             iclk = 1'b0;
    logic             iclk_sync;
    logic             rise;
    logic             fall;
    logic [WIDTH-1:0] factor;
    logic [WIDTH-1:0] high_time;
    logic             locked;
    logic             error;

    int checks = 0;
    int errors = 0;
    int rise_cnt = 0;
    int err_cnt = 0;
    int s_rise;
    int s_err;

    clk_ratio_detector #(
        .MAX_FACTOR (16),
        .LOCK_COUNT (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .iclk     (iclk),
        .iclk_sync(iclk_sync),
        .rise     (rise),
        .fall     (fall),
        .factor   (factor),
        .high_time(high_time),
        .locked   (locked),
        .error    (error)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled on the inactive edge.
    always @(negedge clk) begin
        if (rise === 1'b1) rise_cnt++;
        if (error === 1'b1) err_cnt++;
    end

    task automatic drive_period(input int h, input int l);
        iclk = 1'b1;
        repeat (h) @(negedge clk);
        #1;
        iclk = 1'b0;
        repeat (l) @(negedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        iclk = 1'b0;
        enable = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        iclk = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        checks++; if (iclk_sync !== 1'b0) begin errors++; $display("[TB] FAIL reset_iclk_sync: got %0b expected 0", iclk_sync); end
        checks++; if (rise !== 1'b0) begin errors++; $display("[TB] FAIL reset_rise: got %0b expected 0", rise); end
        checks++; if (fall !== 1'b0) begin errors++; $display("[TB] FAIL reset_fall: got %0b expected 0", fall); end
        checks++; if (factor !== 5'd0) begin errors++; $display("[TB] FAIL reset_factor: got %0d expected 0", factor); end
        checks++; if (high_time !== 5'd0) begin errors++; $display("[TB] FAIL reset_high_time: got %0d expected 0", high_time); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b expected 0", locked); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL reset_error: got %0b expected 0", error); end
        iclk = 1'b0;
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic test_edge_latency();
        pulse_reset();
        iclk = 1'b1;
        @(negedge clk); #1;
        checks++; if (iclk_sync !== 1'b0) begin errors++; $display("[TB] FAIL sync_k1: got %0b expected 0", iclk_sync); end
        @(negedge clk); #1;
        checks++; if (iclk_sync !== 1'b1) begin errors++; $display("[TB] FAIL sync_k2: got %0b expected 1", iclk_sync); end
        checks++; if (rise !== 1'b0) begin errors++; $display("[TB] FAIL rise_k2: got %0b expected 0", rise); end
        @(negedge clk); #1;
        checks++; if (rise !== 1'b1) begin errors++; $display("[TB] FAIL rise_k3: got %0b expected 1", rise); end
        @(negedge clk); #1;
        checks++; if (rise !== 1'b0) begin errors++; $display("[TB] FAIL rise_k4: got %0b expected 0", rise); end
        iclk = 1'b0;
        repeat (2) @(negedge clk); #1;
        checks++; if (fall !== 1'b0) begin errors++; $display("[TB] FAIL fall_k2: got %0b expected 0", fall); end
        @(negedge clk); #1;
        checks++; if (fall !== 1'b1) begin errors++; $display("[TB] FAIL fall_k3: got %0b expected 1", fall); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL edge_error: got %0b expected 0", error); end
    endtask

    task automatic test_lock_div4();
        pulse_reset();
        s_rise = rise_cnt;
        s_err = err_cnt;
        repeat (4) drive_period(2, 2);
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL div4_early_locked: got %0b expected 0", locked); end
        checks++; if (rise_cnt - s_rise !== 4) begin errors++; $display("[TB] FAIL div4_rises: got %0d expected 4", rise_cnt - s_rise); end
        drive_period(2, 2);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL div4_locked: got %0b expected 1", locked); end
        checks++; if (factor !== 5'd4) begin errors++; $display("[TB] FAIL div4_factor: got %0d expected 4", factor); end
        checks++; if (high_time !== 5'd2) begin errors++; $display("[TB] FAIL div4_high_time: got %0d expected 2", high_time); end
        repeat (2) drive_period(2, 2);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL div4_hold_locked: got %0b expected 1", locked); end
        checks++; if (err_cnt - s_err !== 0) begin errors++; $display("[TB] FAIL div4_errors: got %0d expected 0", err_cnt - s_err); end
    endtask

    task automatic test_change_div6();
        s_err = err_cnt;
        drive_period(3, 3);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL chg_first_locked: got %0b expected 1", locked); end
        checks++; if (err_cnt - s_err !== 0) begin errors++; $display("[TB] FAIL chg_first_errors: got %0d expected 0", err_cnt - s_err); end
        drive_period(3, 3);
        checks++; if (err_cnt - s_err !== 1) begin errors++; $display("[TB] FAIL chg_error_pulse: got %0d expected 1", err_cnt - s_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL chg_unlocked: got %0b expected 0", locked); end
        checks++; if (factor !== 5'd4) begin errors++; $display("[TB] FAIL chg_factor_hold: got %0d expected 4", factor); end
        repeat (2) drive_period(3, 3);
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL chg_early_relock: got %0b expected 0", locked); end
        drive_period(3, 3);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL chg_relocked: got %0b expected 1", locked); end
        checks++; if (factor !== 5'd6) begin errors++; $display("[TB] FAIL chg_factor: got %0d expected 6", factor); end
        checks++; if (high_time !== 5'd3) begin errors++; $display("[TB] FAIL chg_high_time: got %0d expected 3", high_time); end
        checks++; if (err_cnt - s_err !== 1) begin errors++; $display("[TB] FAIL chg_total_errors: got %0d expected 1", err_cnt - s_err); end
    endtask

    task automatic test_timeout_div8();
        pulse_reset();
        repeat (5) drive_period(4, 4);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL to_locked: got %0b expected 1", locked); end
        checks++; if (factor !== 5'd8) begin errors++; $display("[TB] FAIL to_factor: got %0d expected 8", factor); end
        checks++; if (high_time !== 5'd4) begin errors++; $display("[TB] FAIL to_high_time: got %0d expected 4", high_time); end
        s_err = err_cnt;
        repeat (12) @(negedge clk);
        #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL to_pre_locked: got %0b expected 1", locked); end
        checks++; if (err_cnt - s_err !== 0) begin errors++; $display("[TB] FAIL to_pre_errors: got %0d expected 0", err_cnt - s_err); end
        @(negedge clk); #1;
        checks++; if (error !== 1'b1) begin errors++; $display("[TB] FAIL to_error: got %0b expected 1", error); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL to_unlocked: got %0b expected 0", locked); end
        repeat (10) @(negedge clk);
        #1;
        checks++; if (err_cnt - s_err !== 1) begin errors++; $display("[TB] FAIL to_error_count: got %0d expected 1", err_cnt - s_err); end
        checks++; if (factor !== 5'd8) begin errors++; $display("[TB] FAIL to_factor_hold: got %0d expected 8", factor); end
    endtask

    task automatic test_alternating();
        pulse_reset();
        s_err = err_cnt;
        for (int i = 0; i < 4; i++) begin
            drive_period(2, 2);
            drive_period(3, 3);
        end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL alt_locked: got %0b expected 0", locked); end
        checks++; if (err_cnt - s_err !== 0) begin errors++; $display("[TB] FAIL alt_errors: got %0d expected 0", err_cnt - s_err); end
        checks++; if (factor !== 5'd0) begin errors++; $display("[TB] FAIL alt_factor: got %0d expected 0", factor); end
        checks++; if (high_time !== 5'd0) begin errors++; $display("[TB] FAIL alt_high_time: got %0d expected 0", high_time); end
    endtask

    task automatic test_div16_glitch();
        pulse_reset();
        repeat (5) drive_period(8, 8);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL d16_locked: got %0b expected 1", locked); end
        checks++; if (factor !== 5'd16) begin errors++; $display("[TB] FAIL d16_factor: got %0d expected 16", factor); end
        checks++; if (high_time !== 5'd8) begin errors++; $display("[TB] FAIL d16_high_time: got %0d expected 8", high_time); end
        s_err = err_cnt;
        drive_period(8, 3);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL d16_pre_glitch: got %0b expected 1", locked); end
        drive_period(1, 4);
        checks++; if (err_cnt - s_err !== 1) begin errors++; $display("[TB] FAIL d16_glitch_error: got %0d expected 1", err_cnt - s_err); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL d16_glitch_unlock: got %0b expected 0", locked); end
        checks++; if (factor !== 5'd16) begin errors++; $display("[TB] FAIL d16_factor_hold: got %0d expected 16", factor); end
    endtask

    task automatic test_reset_measure();
        pulse_reset();
        repeat (3) drive_period(2, 2);
        rst_n = 1'b0;
        iclk = 1'b1;
        @(negedge clk); #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL rm_locked: got %0b expected 0", locked); end
        checks++; if (factor !== 5'd0) begin errors++; $display("[TB] FAIL rm_factor: got %0d expected 0", factor); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL rm_error: got %0b expected 0", error); end
        checks++; if (iclk_sync !== 1'b0) begin errors++; $display("[TB] FAIL rm_iclk_sync: got %0b expected 0", iclk_sync); end
        rst_n = 1'b1;
        iclk = 1'b0;
        repeat (4) drive_period(2, 2);
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL rm_early_lock: got %0b expected 0", locked); end
        drive_period(2, 2);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL rm_relock: got %0b expected 1", locked); end
    endtask

    task automatic test_enable();
        s_rise = rise_cnt;
        s_err = err_cnt;
        enable = 1'b0;
        @(negedge clk); #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL en_locked: got %0b expected 0", locked); end
        checks++; if (error !== 1'b0) begin errors++; $display("[TB] FAIL en_error: got %0b expected 0", error); end
        checks++; if (factor !== 5'd4) begin errors++; $display("[TB] FAIL en_factor_hold: got %0d expected 4", factor); end
        drive_period(2, 2);
        checks++; if (rise_cnt - s_rise !== 1) begin errors++; $display("[TB] FAIL en_rise_tracks: got %0d expected 1", rise_cnt - s_rise); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL en_still_unlocked: got %0b expected 0", locked); end
        enable = 1'b1;
        repeat (4) drive_period(2, 2);
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL en_early_lock: got %0b expected 0", locked); end
        drive_period(2, 2);
        checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL en_relock: got %0b expected 1", locked); end
        checks++; if (err_cnt - s_err !== 0) begin errors++; $display("[TB] FAIL en_errors: got %0d expected 0", err_cnt - s_err); end
    endtask

    initial begin
        @(negedge clk);
        #1;
        test_reset();
        test_edge_latency();
        test_lock_div4();
        test_change_div6();
        test_timeout_div8();
        test_alternating();
        test_div16_glitch();
        test_reset_measure();
        test_enable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
